// File: rtl/coord_run_coalescer.sv
// coord_run_coalescer: pops an ascending coordinate stream from the merge tree,
// collapses runs of equal coordinates into (coord, count) records and queues
// them in a small registered FIFO for the accumulation stage.
//
// Ports:
//   clock, reset   single rising-edge clock, synchronous active-high reset
//   coord          merge-tree head (combinational); all-ones = end of stream
//   selected       pop strobe back to the merge tree
//   restart        re-arms the block once it has reached DONE
//   out_valid/out_ready/out_coord/out_count/out_last  record output handshake
//   done           stream fully consumed and every record drained
//   order_error    sticky: a descending coordinate was popped
module coord_run_coalescer #(
    parameter int COORD_W    = 64,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COORD_W-1:0] coord,
    output logic               selected,
    input  logic               restart,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_coord,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_last,
    output logic               done,
    output logic               order_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [COORD_W-1:0] SENTINEL = {COORD_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [OCC_W-1:0]   OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // open run
    logic               run_valid;
    logic               run_valid_next;
    logic [COORD_W-1:0] run_coord;
    logic [COORD_W-1:0] run_coord_next;
    logic [CNT_W-1:0]   run_count;
    logic [CNT_W-1:0]   run_count_next;

    logic order_set;
    logic order_clr;
    logic order_flag;

    // output FIFO
    logic [COORD_W-1:0] mem_coord [FIFO_DEPTH];
    logic [CNT_W-1:0]   mem_count [FIFO_DEPTH];
    logic               mem_last  [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;

    logic               push;
    logic               push_last;
    logic               pop;
    logic               can_push;
    logic               pop_req;

    logic in_valid;
    logic extend;

    assign in_valid = (coord != SENTINEL);
    assign extend   = run_valid && (coord == run_coord) && (run_count != CNT_MAX);

    assign pop      = out_valid && out_ready;
    // a full FIFO may still accept a record in the cycle its head leaves
    assign can_push = (occ < OCC_FULL) || pop;

    always_comb begin
        state_next     = state;
        pop_req        = 1'b0;
        push           = 1'b0;
        push_last      = 1'b0;
        run_valid_next = run_valid;
        run_coord_next = run_coord;
        run_count_next = run_count;
        order_set      = 1'b0;
        order_clr      = 1'b0;

        unique case (state)
            S_RUN: begin
                if (in_valid) begin
                    if (!run_valid || extend || can_push) begin
                        pop_req = 1'b1;
                        if (extend) begin
                            run_count_next = run_count + CNT_W'(1);
                        end else begin
                            // closes the open run (also when a run saturates
                            // on an equal coordinate) and opens a new one
                            push           = run_valid;
                            run_valid_next = 1'b1;
                            run_coord_next = coord;
                            run_count_next = CNT_W'(1);
                        end
                        if (run_valid && (coord < run_coord)) begin
                            order_set = 1'b1;
                        end
                    end
                end else if (run_valid) begin
                    state_next = S_FLUSH;
                end else begin
                    state_next = S_DONE;
                end
            end

            S_FLUSH: begin
                if (can_push) begin
                    push           = 1'b1;
                    push_last      = 1'b1;
                    run_valid_next = 1'b0;
                    state_next     = S_DONE;
                end
            end

            S_DONE: begin
                if (restart) begin
                    state_next     = S_RUN;
                    run_valid_next = 1'b0;
                    run_coord_next = '0;
                    run_count_next = '0;
                    order_clr      = 1'b1;
                end
            end

            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_RUN;
            run_valid  <= 1'b0;
            run_coord  <= '0;
            run_count  <= '0;
            order_flag <= 1'b0;
        end else begin
            state      <= state_next;
            run_valid  <= run_valid_next;
            run_coord  <= run_coord_next;
            run_count  <= run_count_next;
            if (order_clr) begin
                order_flag <= 1'b0;
            end else if (order_set) begin
                order_flag <= 1'b1;
            end
        end
    end

    // storage itself needs no reset: the head is masked while empty
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_coord[wr_ptr] <= run_coord;
            mem_count[wr_ptr] <= run_count;
            mem_last[wr_ptr]  <= push_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign out_valid   = (occ != '0);
    assign out_coord   = out_valid ? mem_coord[rd_ptr] : '0;
    assign out_count   = out_valid ? mem_count[rd_ptr] : '0;
    assign out_last    = out_valid ? mem_last[rd_ptr]  : 1'b0;

    assign selected    = pop_req && !reset;
    assign done        = (state == S_DONE) && (occ == '0);
    assign order_error = order_flag;

endmodule

// File: tb/tb_coord_run_coalescer.sv
// tb_coord_run_coalescer: directed vectors for the run coalescer with a
// simple merge-tree head model and an output record collector.
module tb_coord_run_coalescer;

    localparam int CW = 64;
    localparam int NW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          restart = 1'b0;
    logic          out_ready = 1'b1;
    logic [CW-1:0] coord;
    logic          selected;
    logic          out_valid;
    logic [CW-1:0] out_coord;
    logic [NW-1:0] out_count;
    logic          out_last;
    logic          done;
    logic          order_error;

    coord_run_coalescer #(
        .COORD_W(CW),
        .CNT_W(NW),
        .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .coord(coord),
        .selected(selected),
        .restart(restart),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_coord(out_coord),
        .out_count(out_count),
        .out_last(out_last),
        .done(done),
        .order_error(order_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [NW-1:0] n;
        logic          l;
    } rec_t;

    logic [CW-1:0] stream_mem [0:511];
    int            stream_len = 0;
    int            idx = 0;
    int            sel_cnt = 0;
    rec_t          got_q [$];

    assign coord = (idx < stream_len) ? stream_mem[idx] : {CW{1'b1}};

    always @(posedge clock) begin
        if (reset) begin
            idx     <= 0;
            sel_cnt <= 0;
            got_q.delete();
        end else begin
            if (selected) begin
                idx     <= idx + 1;
                sel_cnt <= sel_cnt + 1;
            end
            if (out_valid && out_ready) begin
                got_q.push_back({out_coord, out_count, out_last});
            end
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
    endtask

    // stream element 0 and record 0 are the rightmost entries
    typedef struct packed {
        int                 len;
        logic [7:0][CW-1:0] s;
        int                 nrec;
        logic [3:0][CW-1:0] ec;
        logic [3:0][NW-1:0] en;
        logic [3:0]         el;
        logic               err;
        int                 nsel;
        int                 lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check_recs(input string tag, input int n,
                              input logic [3:0][CW-1:0] ec,
                              input logic [3:0][NW-1:0] en,
                              input logic [3:0] el);
        check($sformatf("%s nrec", tag), 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s rec%0d coord", tag, i), got_q[i].c, ec[i]);
                check($sformatf("%s rec%0d count", tag, i),
                      64'(got_q[i].n), 64'(en[i]));
                check($sformatf("%s rec%0d last", tag, i),
                      64'(got_q[i].l), 64'(el[i]));
            end
        end
    endtask

    initial begin
        int cyc;
        string tag;

        vecs[0] = '{len: 6,
            s: {64'd0, 64'd0, 64'd9, 64'd9, 64'd7, 64'd3, 64'd3, 64'd3},
            nrec: 3, ec: {64'd0, 64'd9, 64'd7, 64'd3},
            en: {8'd0, 8'd2, 8'd1, 8'd3}, el: 4'b0100,
            err: 1'b0, nsel: 6, lat: 9};
        vecs[1] = '{len: 0, s: '0, nrec: 0, ec: '0, en: '0, el: 4'b0000,
            err: 1'b0, nsel: 0, lat: 1};
        vecs[2] = '{len: 3,
            s: {64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd2, 64'd2, 64'd4},
            nrec: 2, ec: {64'd0, 64'd0, 64'd2, 64'd4},
            en: {8'd0, 8'd0, 8'd2, 8'd1}, el: 4'b0010,
            err: 1'b1, nsel: 3, lat: -1};
        vecs[3] = '{len: 1,
            s: {64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd42},
            nrec: 1, ec: {64'd0, 64'd0, 64'd0, 64'd42},
            en: {8'd0, 8'd0, 8'd0, 8'd1}, el: 4'b0001,
            err: 1'b0, nsel: 1, lat: 4};
        vecs[4] = '{len: 6,
            s: {64'd0, 64'd0, 64'd5, 64'd2, 64'd2, 64'd2, 64'd1, 64'd1},
            nrec: 3, ec: {64'd0, 64'd5, 64'd2, 64'd1},
            en: {8'd0, 8'd1, 8'd3, 8'd2}, el: 4'b0100,
            err: 1'b0, nsel: 6, lat: -1};
        vecs[5] = '{len: 3,
            s: {64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0},
            nrec: 2, ec: {64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0},
            en: {8'd0, 8'd0, 8'd1, 8'd2}, el: 4'b0010,
            err: 1'b0, nsel: 3, lat: -1};

        // reset values
        @(posedge clock);
        @(negedge clock);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_coord", out_coord, 64'd0);
        check("rst out_count", 64'(out_count), 64'd0);
        check("rst out_last", 64'(out_last), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst order_error", 64'(order_error), 64'd0);
        check("rst selected", 64'(selected), 64'd0);

        // table-driven streams
        for (int v = 0; v < 6; v++) begin
            tag = $sformatf("vec%0d", v);
            for (int i = 0; i < 8; i++) begin
                stream_mem[i] = vecs[v].s[i];
            end
            stream_len = vecs[v].len;
            out_ready  = 1'b1;
            pulse_reset();
            wait_done(cyc);
            check({tag, " done"}, 64'(done), 64'd1);
            if (vecs[v].lat >= 0) begin
                check({tag, " latency"}, 64'(cyc), 64'(vecs[v].lat));
            end
            check_recs(tag, vecs[v].nrec, vecs[v].ec, vecs[v].en, vecs[v].el);
            check({tag, " order_error"}, 64'(order_error), 64'(vecs[v].err));
            check({tag, " sel pulses"}, 64'(sel_cnt), 64'(vecs[v].nsel));
            restart = 1'b1;
            @(posedge clock);
            @(negedge clock);
            restart = 1'b0;
            check({tag, " restart order_error"}, 64'(order_error), 64'd0);
            check({tag, " restart done"}, 64'(done), 64'd0);
        end

        // count saturation: 300 copies of 5
        for (int i = 0; i < 300; i++) begin
            stream_mem[i] = 64'd5;
        end
        stream_len = 300;
        out_ready  = 1'b1;
        pulse_reset();
        wait_done(cyc);
        check("sat done", 64'(done), 64'd1);
        check_recs("sat", 2, {64'd0, 64'd0, 64'd5, 64'd5},
                   {8'd0, 8'd0, 8'd45, 8'd255}, 4'b0010);
        check("sat sel pulses", 64'(sel_cnt), 64'd300);

        // backpressure: distinct 1..10 with out_ready low
        for (int i = 0; i < 10; i++) begin
            stream_mem[i] = 64'(i + 1);
        end
        stream_len = 10;
        out_ready  = 1'b0;
        pulse_reset();
        repeat (20) @(negedge clock);
        check("bp selected", 64'(selected), 64'd0);
        check("bp head", coord, 64'd6);
        check("bp out_valid", 64'(out_valid), 64'd1);
        check("bp out_coord", out_coord, 64'd1);
        check("bp no pops", 64'(got_q.size()), 64'd0);
        out_ready = 1'b1;
        wait_done(cyc);
        check("bp done", 64'(done), 64'd1);
        check("bp nrec", 64'(got_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("bp rec%0d coord", i), got_q[i].c, 64'(i + 1));
                check($sformatf("bp rec%0d count", i), 64'(got_q[i].n), 64'd1);
                check($sformatf("bp rec%0d last", i), 64'(got_q[i].l),
                      64'(i == 9));
            end
        end

        // reset mid-stream with a run open and one record queued
        stream_mem[0] = 64'd7;
        stream_mem[1] = 64'd8;
        stream_mem[2] = 64'd8;
        stream_mem[3] = 64'd9;
        stream_len = 4;
        out_ready  = 1'b0;
        pulse_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("mid queued valid", 64'(out_valid), 64'd1);
        check("mid queued coord", out_coord, 64'd7);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("mid rst out_valid", 64'(out_valid), 64'd0);
        check("mid rst selected", 64'(selected), 64'd0);
        check("mid rst out_count", 64'(out_count), 64'd0);
        stream_mem[0] = 64'd1;
        stream_mem[1] = 64'd1;
        stream_len = 2;
        out_ready  = 1'b1;
        reset      = 1'b0;
        wait_done(cyc);
        check("mid done", 64'(done), 64'd1);
        check_recs("mid", 1, {64'd0, 64'd0, 64'd0, 64'd1},
                   {8'd0, 8'd0, 8'd0, 8'd2}, 4'b0001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
